// File: rtl/conversor_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package conversor_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    CONVERTE,
    FIM
  } estado_t;

  localparam int         DIGITO_W      = 4;
  localparam logic [3:0] LIMIAR_AJUSTE = 4'd5;

endpackage

// File: rtl/conversor_bcd_if.sv
// Start/busy/done handshake and result bus between the datapath and the BCD converter.
interface conversor_bcd_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) ();

  logic                  inicio;
  logic [WIDTH-1:0]      valor;
  logic                  ocupado;
  logic                  pronto;
  logic [4*DIGITS-1:0]   bcd_saida;
  logic                  estouro;
  logic                  negativo;

  modport master (
    output inicio, valor,
    input  ocupado, pronto, bcd_saida, estouro, negativo
  );

  modport slave (
    input  inicio, valor,
    output ocupado, pronto, bcd_saida, estouro, negativo
  );

endinterface

// File: rtl/ajuste_digito.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more before the shift.
module ajuste_digito
  import conversor_pkg::*;
(
  input  logic [DIGITO_W-1:0] i_digito,
  output logic [DIGITO_W-1:0] o_digito
);

  assign o_digito = (i_digito >= LIMIAR_AJUSTE) ? i_digito + 4'd3 : i_digito;

endmodule

// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Define CONVERSOR_SINAL_EN to treat valor as two's complement and report its sign.
module conversor_bcd
  import conversor_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic            clock,
  input  logic            reset,
  conversor_bcd_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = DIGITO_W * DIGITS;

  estado_t          r_estado;
  logic [WIDTH-1:0] r_desloc;
  logic [BCD_W-1:0] r_rascunho;
  logic             r_acum;
  logic [CNT_W-1:0] r_contador;
  logic [BCD_W-1:0] r_bcd;
  logic             r_estouro;
  logic             r_ocupado;
  logic             r_pronto;

  logic [BCD_W-1:0] w_ajustado;
  logic [BCD_W-1:0] w_prox_rascunho;
  logic             w_saida_topo;
  logic [WIDTH-1:0] w_magnitude;
  logic             w_aceita;
  logic             w_termina;

  for (genvar g = 0; g < DIGITS; g++) begin : g_ajuste
    ajuste_digito u_ajuste (
      .i_digito (r_rascunho[g*DIGITO_W +: DIGITO_W]),
      .o_digito (w_ajustado[g*DIGITO_W +: DIGITO_W])
    );
  end

  // The bit leaving the top digit is lost from the result and marks overflow.
  assign w_saida_topo    = w_ajustado[BCD_W-1];
  assign w_prox_rascunho = {w_ajustado[BCD_W-2:0], r_desloc[WIDTH-1]};
  assign w_aceita        = (r_estado != CONVERTE) && bus.inicio;
  assign w_termina       = (r_estado == CONVERTE) && (r_contador == CNT_W'(1));

`ifdef CONVERSOR_SINAL_EN
  // Negating the most-negative value wraps back to itself, which read unsigned is its magnitude.
  assign w_magnitude = bus.valor[WIDTH-1] ? (WIDTH'(0) - bus.valor) : bus.valor;
`else
  assign w_magnitude = bus.valor;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the datapath scratch is reset along with the outputs so a reset
      // mid-conversion leaves nothing undefined behind.
      r_estado   <= OCIOSO;
      r_desloc   <= '0;
      r_rascunho <= '0;
      r_acum     <= 1'b0;
      r_contador <= '0;
      r_bcd      <= '0;
      r_estouro  <= 1'b0;
      r_ocupado  <= 1'b0;
      r_pronto   <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO, FIM: begin
          r_pronto <= 1'b0;
          if (bus.inicio) begin
            r_desloc   <= w_magnitude;
            r_rascunho <= '0;
            r_acum     <= 1'b0;
            r_contador <= CNT_W'(WIDTH);
            r_estado   <= CONVERTE;
            r_ocupado  <= 1'b1;
          end else begin
            r_estado <= OCIOSO;
          end
        end
        CONVERTE: begin
          r_desloc   <= {r_desloc[WIDTH-2:0], 1'b0};
          r_rascunho <= w_prox_rascunho;
          r_acum     <= r_acum | w_saida_topo;
          r_contador <= r_contador - CNT_W'(1);
          if (r_contador == CNT_W'(1)) begin
            r_bcd     <= w_prox_rascunho;
            r_estouro <= r_acum | w_saida_topo;
            r_estado  <= FIM;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b1;
          end
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

`ifdef CONVERSOR_SINAL_EN
  logic r_sinal;
  logic r_negativo;

  // The sign is captured with the operand but only published with the result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sinal    <= 1'b0;
      r_negativo <= 1'b0;
    end else if (w_aceita) begin
      r_sinal <= bus.valor[WIDTH-1];
    end else if (w_termina) begin
      r_negativo <= r_sinal;
    end
  end

  assign bus.negativo = r_negativo;
`else
  assign bus.negativo = 1'b0;
`endif

  assign bus.ocupado   = r_ocupado;
  assign bus.pronto    = r_pronto;
  assign bus.bcd_saida = r_bcd;
  assign bus.estouro   = r_estouro;

endmodule

// File: tb/tb_conversor_bcd.sv
// Self-checking bench for conversor_bcd: decimal-arithmetic model plus directed vectors.
module tb_conversor_bcd;

  logic  clock = 1'b0;
  logic  reset;
  longint cyc = 0;
  logic  rst_amostrado = 1'b1;

  always #5 clock = ~clock;
  always @(posedge clock) begin
    cyc           <= cyc + 1;
    rst_amostrado <= reset;
  end

  conversor_bcd_if #(.WIDTH(32), .DIGITS(10)) bus ();
  conversor_bcd #(.WIDTH(32), .DIGITS(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  conversor_bcd_if #(.WIDTH(10), .DIGITS(3)) bus_p ();
  conversor_bcd #(.WIDTH(10), .DIGITS(3)) dut_p (
    .clock (clock),
    .reset (reset),
    .bus   (bus_p)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
    n_vec++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nome, atual, esperado, cyc);
    end
  endtask

  // Decimal model: magnitude by arithmetic, digits by repeated division.
  task automatic modelo(input logic [31:0] v, output logic [39:0] bcd, output logic est,
                        output logic neg);
    longint unsigned m;
`ifdef CONVERSOR_SINAL_EN
    m   = v[31] ? (64'h1_0000_0000 - 64'(v)) : 64'(v);
    neg = v[31];
`else
    m   = 64'(v);
    neg = 1'b0;
`endif
    bcd = '0;
    for (int i = 0; i < 10; i++) begin
      bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    est = (m != 0);
  endtask

  typedef struct {
    longint      e0;
    logic [31:0] valor;
  } conv_t;

  conv_t       fila[$];
  logic [39:0] exp_bcd = '0;
  logic        exp_est = 1'b0;
  logic        exp_neg = 1'b0;

  always @(negedge clock) begin
    logic e_ocup;
    logic e_pront;
    e_ocup  = 1'b0;
    e_pront = 1'b0;
    if (rst_amostrado) begin
      fila.delete();
      exp_bcd = '0;
      exp_est = 1'b0;
      exp_neg = 1'b0;
    end else if (fila.size() > 0) begin
      e_ocup  = (cyc >= fila[0].e0) && (cyc < fila[0].e0 + 32);
      e_pront = (cyc == fila[0].e0 + 32);
      if (e_pront) begin
        modelo(fila[0].valor, exp_bcd, exp_est, exp_neg);
        void'(fila.pop_front());
      end
    end
    check("ocupado", 64'(bus.ocupado), 64'(e_ocup));
    check("pronto", 64'(bus.pronto), 64'(e_pront));
    check("bcd_saida", 64'(bus.bcd_saida), 64'(exp_bcd));
    check("estouro", 64'(bus.estouro), 64'(exp_est));
    check("negativo", 64'(bus.negativo), 64'(exp_neg));
    if (e_pront) begin
      for (int i = 0; i < 10; i++)
        check("digito_0_9", 64'(bus.bcd_saida[4*i +: 4] <= 4'd9), 64'(1));
    end
  end

  task automatic iniciar(input logic [31:0] v, output longint e0);
    @(negedge clock);
    bus.valor  = v;
    bus.inicio = 1'b1;
    e0 = cyc + 1;
    fila.push_back('{e0: e0, valor: v});
    @(negedge clock);
    bus.inicio = 1'b0;
  endtask

  task automatic esperar_pronto(output longint quando);
    int k = 0;
    while (!bus.pronto && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("pronto_dentro_do_prazo", 64'(bus.pronto), 64'(1));
    quando = cyc;
  endtask

  task automatic converter_p(input logic [9:0] v, output logic ok);
    int k = 0;
    @(negedge clock);
    bus_p.valor  = v;
    bus_p.inicio = 1'b1;
    @(negedge clock);
    bus_p.inicio = 1'b0;
    while (!bus_p.pronto && k < 40) begin
      @(negedge clock);
      k++;
    end
    ok = bus_p.pronto;
  endtask

  initial begin
    longint e0, t1, t2;
    int     n;
    logic   ok;

    reset        = 1'b1;
    bus.inicio   = 1'b0;
    bus.valor    = '0;
    bus_p.inicio = 1'b0;
    bus_p.valor  = '0;
    repeat (3) @(negedge clock);
    check("reset_ocupado", 64'(bus.ocupado), 64'(0));
    check("reset_bcd", 64'(bus.bcd_saida), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Zero: ocupado for exactly WIDTH cycles, pronto at E0+32.
    iniciar(32'd0, e0);
    n = 0;
    while (bus.ocupado && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("ocupado_ciclos", 64'(n), 64'(32));
    check("pronto_em_e0_32", 64'(bus.pronto), 64'(1));
    check("latencia_zero", 64'(cyc - e0), 64'(32));
    check("zero_bcd", 64'(bus.bcd_saida), 64'h0);
    check("zero_estouro", 64'(bus.estouro), 64'(0));
    @(negedge clock);
    check("pronto_um_ciclo", 64'(bus.pronto), 64'(0));

`ifndef CONVERSOR_SINAL_EN
    iniciar(32'hFFFF_FFFF, e0);
    esperar_pronto(t1);
    check("max_bcd", 64'(bus.bcd_saida), 64'h42_9496_7295);
    check("max_estouro", 64'(bus.estouro), 64'(0));
`else
    iniciar(32'hFFFF_FFFF, e0);
    esperar_pronto(t1);
    check("menos_um_bcd", 64'(bus.bcd_saida), 64'h1);
    check("menos_um_negativo", 64'(bus.negativo), 64'(1));
    iniciar(32'h8000_0000, e0);
    esperar_pronto(t1);
    check("mais_negativo_bcd", 64'(bus.bcd_saida), 64'h21_4748_3648);
    check("mais_negativo_negativo", 64'(bus.negativo), 64'(1));
`endif
    repeat (3) @(negedge clock);

    // Back-to-back: inicio held high through FIM.
    @(negedge clock);
    bus.valor  = 32'd1234;
    bus.inicio = 1'b1;
    e0 = cyc + 1;
    fila.push_back('{e0: e0, valor: 32'd1234});
    fila.push_back('{e0: e0 + 33, valor: 32'd56789});
    @(negedge clock);
    bus.valor = 32'd56789;
    esperar_pronto(t1);
    check("b2b_primeiro", 64'(bus.bcd_saida), 64'h1234);
    @(negedge clock);
    bus.inicio = 1'b0;
    esperar_pronto(t2);
    check("b2b_segundo", 64'(bus.bcd_saida), 64'h5_6789);
    check("b2b_intervalo", 64'(t2 - t1), 64'(33));
    repeat (5) @(negedge clock);
    check("resultado_mantido", 64'(bus.bcd_saida), 64'h5_6789);

    // inicio and a new valor mid-conversion are ignored.
    iniciar(32'd777777, e0);
    repeat (5) @(negedge clock);
    bus.valor  = 32'd123;
    bus.inicio = 1'b1;
    repeat (3) @(negedge clock);
    bus.inicio = 1'b0;
    esperar_pronto(t1);
    check("ignora_inicio", 64'(bus.bcd_saida), 64'h77_7777);
    check("ignora_latencia", 64'(t1 - e0), 64'(32));
    repeat (2) @(negedge clock);

    // Reset at E0+10 aborts the conversion.
    iniciar(32'd99999, e0);
    while (cyc < e0 + 9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_ocupado", 64'(bus.ocupado), 64'(0));
    check("abort_bcd", 64'(bus.bcd_saida), 64'h0);
    reset = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.pronto) n++;
    end
    check("abort_sem_pronto", 64'(n), 64'(0));

`ifndef CONVERSOR_SINAL_EN
    converter_p(10'd1000, ok);
    check("p_pronto_1000", 64'(ok), 64'(1));
    check("p_estouro_1000", 64'(bus_p.estouro), 64'(1));
    check("p_bcd_1000", 64'(bus_p.bcd_saida), 64'h000);
    converter_p(10'd999, ok);
    check("p_pronto_999", 64'(ok), 64'(1));
    check("p_estouro_999", 64'(bus_p.estouro), 64'(0));
    check("p_bcd_999", 64'(bus_p.bcd_saida), 64'h999);
    check("p_negativo", 64'(bus_p.negativo), 64'(0));
`else
    converter_p(10'h200, ok);
    check("p_pronto_min", 64'(ok), 64'(1));
    check("p_bcd_min", 64'(bus_p.bcd_saida), 64'h512);
    check("p_negativo_min", 64'(bus_p.negativo), 64'(1));
    check("p_estouro_min", 64'(bus_p.estouro), 64'(0));
`endif
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conversor_bcd.md
# conversor_bcd

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It takes a binary value from the datapath (a register or ALU result selected for display) and produces packed BCD digits. Each 4-bit digit feeds one per-digit seven-segment decoder downstream. A start/busy/done handshake sequences each conversion. Output digits are registered and held until the next conversion completes.

## Interface
- `WIDTH`, 32: bit width of the binary input.
- `DIGITS`, 10: number of BCD digits produced. 10 covers 2^32−1.

- `clock`  in  1  : single clock. All state changes on the rising edge.
- `reset`  in  1  : synchronous, active-high.
- `inicio`  in  1  : start request, sampled on the rising edge.
- `valor`  in  WIDTH  : binary operand, captured on the accepting edge only.
- `ocupado`  out  1  : conversion in progress.
- `pronto`  out  1  : one-cycle pulse; `bcd_saida` is updated and valid.
- `bcd_saida`  out  4*DIGITS  : packed digits, digit 0 (units) in bits [3:0].
- `estouro`  out  1  : result exceeded DIGITS digits. Valid with `pronto` and held.
- `negativo`  out  1  : sign of the last result (see Configuration).

## Operation
- FSM has three states: OCIOSO, CONVERTE, FIM.
- OCIOSO or FIM, with `inicio`=1:
  - load `valor` into the shift register;
  - clear the BCD scratch and the overflow accumulator;
  - set the counter to WIDTH;
  - go to CONVERTE.
- CONVERTE, each cycle:
  - add 3 to every scratch digit that is ≥5;
  - shift {scratch, shift register} left by 1;
  - OR the bit shifted out of the top digit into the overflow accumulator;
  - decrement the counter.
- CONVERTE, on the shift where the counter goes 1→0:
  - load `bcd_saida` with the final scratch and `estouro` with the accumulator;
  - go to FIM.
- FIM, with `inicio`=0: go to OCIOSO.
- `inicio` in CONVERTE is ignored. It is not queued.
- `ocupado` = (state==CONVERTE). `pronto` = (state==FIM).
- `valor` changes after the accepting edge have no effect.
- Reset values: state OCIOSO, `ocupado`=0, `pronto`=0, `bcd_saida`=0, `estouro`=0, `negativo`=0.
- Reset during CONVERTE aborts the conversion. No `pronto` is produced, and outputs take their reset values.
- Every digit of `bcd_saida` is always in 0–9.

## Timing
- Let the accepting edge be E0.
  - `ocupado` is high from E0 to E0+WIDTH.
  - `bcd_saida` and `pronto` update at E0+WIDTH.
  - `pronto` is high for exactly one cycle.
  - Latency is WIDTH cycles (32 by default).
- Back-to-back: `inicio` held high during FIM starts the next conversion at that edge. Sustained throughput is one result per WIDTH+1 cycles.
- `bcd_saida`, `estouro` and `negativo` are stable from one `pronto` to the next.

## Configuration
- `CONVERSOR_SINAL_EN` defined:
  - `valor` is two's complement;
  - the magnitude is loaded into the shift register;
  - `negativo` loads the sign bit at E0+WIDTH.
  - The most-negative value converts its full magnitude; for WIDTH=32 that is 2147483648.
- `CONVERSOR_SINAL_EN` undefined:
  - `valor` is unsigned;
  - `negativo` is tied to 0.

## Structure
- Package `conversor_pkg` holds:
  - the state type (OCIOSO, CONVERTE, FIM);
  - the BCD digit width constant (4);
  - the add-3 threshold constant (5).
- Sub-module `ajuste_digito`: combinational, 4-bit in/out, adds 3 if the input is ≥5. One instance per digit via generate.
- Counter width is $clog2(WIDTH+1).

## Test plan
- Reset, then `valor`=0, `inicio` pulse:
  - `ocupado` high for 32 cycles;
  - `pronto` rises at E0+32;
  - `bcd_saida`=0, `estouro`=0.
- `valor`=4294967295 → `bcd_saida` digits 4,2,9,4,9,6,7,2,9,5 (MSD→LSD), `estouro`=0.
- `valor`=1234; then `valor`=56789 with `inicio` held high during FIM:
  - first `pronto` shows 1234;
  - second shows 56789 exactly 33 cycles later.
- `inicio` re-asserted mid-conversion with a different `valor` → ignored; the result matches the originally captured value.
- `reset` at E0+10 → `ocupado`=0 next cycle, no `pronto`, `bcd_saida`=0.
- WIDTH=10, DIGITS=3, `valor`=1000 → `estouro`=1, `bcd_saida`=000.
- With `CONVERSOR_SINAL_EN`, `valor`=0xFFFFFFFF → `negativo`=1, `bcd_saida`=1.
